word_ser: RTL and testbench

Parallel-to-serial transmitter for 4-bit register words. It is the unloading end of the parallel-load register path: it accepts one word per valid/ready handshake and shifts it onto a single serial line. Each frame is a low start bit, WIDTH data bits LSB-first, and a high stop bit, with every bit held DIV clock cycles. It is the source that feeds the matching serial-in/parallel-load receiver on the same board-level link.

---
 rtl/word_ser_pkg.sv | 27 ++
 rtl/word_ser_tick.sv | 38 +++
 rtl/word_ser.sv | 115 +++++++++++
 tb/tb_word_ser.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/word_ser_pkg.sv
// rtl/word_ser_pkg.sv - shared types and sizing helpers for the word serialiser
package word_ser_pkg;

  // Line phase of the transmitter
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Counter width for a modulus of n, never narrower than one bit
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  // Bits on the line per frame: start + data + stop
  function automatic int frame_bits(input int width);
    return width + 2;
  endfunction

  localparam int DEF_WIDTH      = 4;
  localparam int DEF_FRAME_BITS = DEF_WIDTH + 2;

endpackage

// File: rtl/word_ser_tick.sv
// rtl/word_ser_tick.sv - bit-period timer with terminal-count decode
module word_ser_tick
  import word_ser_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic r,
  input  logic clear,
  input  logic run,
  output logic tc,
  output logic pre_tc
);

  localparam int TW = cnt_width(DIV);
  localparam int PRE_I = (DIV >= 2) ? DIV - 2 : 0;
  localparam logic [TW-1:0] LAST_CNT = TW'(DIV - 1);
  localparam logic [TW-1:0] PRE_CNT  = TW'(PRE_I);

  logic [TW-1:0] cnt;

  // Count 0..DIV-1 while a frame is on the line; an accept restarts the bit period
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
    end
  end

  assign tc = run & (cnt == LAST_CNT);

  // Next cycle will be the terminal one (with DIV=1 every cycle is terminal)
  assign pre_tc = (DIV == 1) ? 1'b1 : (run & (cnt == PRE_CNT));

endmodule

// File: rtl/word_ser.sv
// rtl/word_ser.sv - parallel-to-serial framed transmitter, LSB first
module word_ser
  import word_ser_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             r,
  input  logic [WIDTH-1:0] D,
  input  logic             valid,
  output logic             ready,
  output logic             sdo,
  output logic             busy
);

  localparam int IW = cnt_width(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);
  // On entry to STOP the first stop cycle is already terminal only when DIV=1
  localparam logic STOP_READY_ON_ENTRY = (DIV == 1);

  state_t           state;
  logic [WIDTH-1:0] shift;
  logic [WIDTH-1:0] shift_nx;
  logic [IW-1:0]    idx;
  logic             accept;
  logic             tc;
  logic             pre_tc;

  assign accept   = valid & ready;
  assign shift_nx = shift >> 1;

  word_ser_tick #(
    .DIV(DIV)
  ) u_tick (
    .clk   (clk),
    .r     (r),
    .clear (accept),
    .run   (state != IDLE),
    .tc    (tc),
    .pre_tc(pre_tc)
  );

  // Frame sequencer; outputs are registered so they reflect the state being entered
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      state <= IDLE;
      shift <= '0;
      idx   <= '0;
      sdo   <= 1'b1;
      busy  <= 1'b0;
      ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= START;
            shift <= D;
            idx   <= '0;
            sdo   <= 1'b0;
            busy  <= 1'b1;
            ready <= 1'b0;
          end
        end
        START: begin
          if (tc) begin
            state <= DATA;
            sdo   <= shift[0];
          end
        end
        DATA: begin
          if (tc) begin
            shift <= shift_nx;
            if (idx == LAST_IDX) begin
              state <= STOP;
              idx   <= '0;
              sdo   <= 1'b1;
              ready <= STOP_READY_ON_ENTRY;
            end else begin
              idx <= idx + 1'b1;
              sdo <= shift_nx[0];
            end
          end
        end
        STOP: begin
          if (tc) begin
            if (accept) begin
              // Chain straight into the next frame with no idle gap
              state <= START;
              shift <= D;
              idx   <= '0;
              sdo   <= 1'b0;
              busy  <= 1'b1;
              ready <= 1'b0;
            end else begin
              state <= IDLE;
              sdo   <= 1'b1;
              busy  <= 1'b0;
              ready <= 1'b1;
            end
          end else begin
            ready <= pre_tc;
          end
        end
        default: begin
          state <= IDLE;
          sdo   <= 1'b1;
          busy  <= 1'b0;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_word_ser.sv
// tb/tb_word_ser.sv - self-checking bench for word_ser against a frame-timing model
module tb_word_ser;

  localparam int W  = 4;
  localparam int DV = 4;
  localparam int FL = (W + 2) * DV;
  localparam int FL1 = (W + 2);

  logic         clk = 1'b0;
  logic         r;
  logic [W-1:0] d;
  logic         valid;
  logic         ready;
  logic         sdo;
  logic         busy;
  logic [W-1:0] d1;
  logic         valid1;
  logic         ready1;
  logic         sdo1;
  logic         busy1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  word_ser #(.WIDTH(W), .DIV(DV)) u_dut (
    .clk  (clk),
    .r    (r),
    .D    (d),
    .valid(valid),
    .ready(ready),
    .sdo  (sdo),
    .busy (busy)
  );

  word_ser #(.WIDTH(W), .DIV(1)) u_dut1 (
    .clk  (clk),
    .r    (r),
    .D    (d1),
    .valid(valid1),
    .ready(ready1),
    .sdo  (sdo1),
    .busy (busy1)
  );

  // Line level in cycle k (1-based) of a frame carrying w with div cycles per bit
  function automatic logic exp_sdo(input logic [W-1:0] w, input int div, input int k);
    int b;
    b = (k - 1) / div;
    if (b == 0) return 1'b0;
    if (b <= W) return w[b-1];
    return 1'b1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    r = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({sdo, busy, ready} !== 3'b101) begin
        errors++;
        $display("FAIL reset_hold cyc %0d got sdo/busy/ready %b exp 101", i, {sdo, busy, ready});
      end
    end
    r = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if ({sdo, busy, ready, sdo1, busy1, ready1} !== 6'b101101) begin
        errors++;
        $display("FAIL idle cyc %0d got %b exp 101101", i, {sdo, busy, ready, sdo1, busy1, ready1});
      end
    end
  endtask

  task automatic test_frame(input logic [W-1:0] w, input bit scramble, input string name);
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before_accept got %b exp 1", name, ready);
    end
    d = w;
    valid = 1'b1;
    step();
    valid = 1'b0;
    for (int k = 1; k <= FL; k++) begin
      if (k > 1) step();
      if (scramble) d = W'($urandom);
      checks++;
      if ({sdo, busy, ready} !== {exp_sdo(w, DV, k), 1'b1, (k == FL)}) begin
        errors++;
        $display("FAIL %s cyc %0d word %h got sdo/busy/ready %b exp %b", name, k, w,
                 {sdo, busy, ready}, {exp_sdo(w, DV, k), 1'b1, (k == FL)});
      end
    end
    step();
    checks++;
    if ({sdo, busy, ready} !== 3'b101) begin
      errors++;
      $display("FAIL %s post_frame_idle got %b exp 101", name, {sdo, busy, ready});
    end
  endtask

  task automatic test_single();
    test_frame(4'b1010, 1'b0, "single");
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w0;
    logic [W-1:0] w1;
    logic         e;
    w0 = 4'hF;
    w1 = 4'h0;
    d = w0;
    valid = 1'b1;
    step();
    d = w1;
    for (int k = 1; k <= 2 * FL; k++) begin
      if (k > 1) step();
      if (k == FL + 1) valid = 1'b0;
      e = (k <= FL) ? exp_sdo(w0, DV, k) : exp_sdo(w1, DV, k - FL);
      checks++;
      if ({sdo, busy, ready} !== {e, 1'b1, (k == FL) || (k == 2 * FL)}) begin
        errors++;
        $display("FAIL b2b cyc %0d got sdo/busy/ready %b exp %b", k, {sdo, busy, ready},
                 {e, 1'b1, (k == FL) || (k == 2 * FL)});
      end
    end
    step();
    checks++;
    if ({sdo, busy, ready} !== 3'b101) begin
      errors++;
      $display("FAIL b2b post_idle got %b exp 101", {sdo, busy, ready});
    end
  endtask

  task automatic test_d_change();
    d = 4'h5;
    valid = 1'b1;
    step();
    valid = 1'b0;
    for (int k = 1; k <= FL; k++) begin
      if (k > 1) step();
      if (k == 2) d = 4'hA;
      checks++;
      if (sdo !== exp_sdo(4'h5, DV, k)) begin
        errors++;
        $display("FAIL dchange cyc %0d got sdo %b exp %b", k, sdo, exp_sdo(4'h5, DV, k));
      end
    end
    step();
  endtask

  task automatic test_reset_mid();
    d = 4'h3;
    valid = 1'b1;
    step();
    valid = 1'b0;
    for (int k = 2; k <= 10; k++) step();
    checks++;
    if ({sdo, busy} !== {exp_sdo(4'h3, DV, 10), 1'b1}) begin
      errors++;
      $display("FAIL rstmid pre got sdo/busy %b exp %b", {sdo, busy}, {exp_sdo(4'h3, DV, 10), 1'b1});
    end
    r = 1'b0;
    #1;
    checks++;
    if ({sdo, busy, ready} !== 3'b101) begin
      errors++;
      $display("FAIL rstmid async got %b exp 101", {sdo, busy, ready});
    end
    step();
    r = 1'b1;
    step();
    checks++;
    if ({sdo, busy, ready} !== 3'b101) begin
      errors++;
      $display("FAIL rstmid released got %b exp 101", {sdo, busy, ready});
    end
    test_frame(4'h8, 1'b0, "after_rst");
  endtask

  task automatic test_div1();
    logic [W-1:0] w;
    w = 4'b0110;
    checks++;
    if (ready1 !== 1'b1) begin
      errors++;
      $display("FAIL div1 ready_before got %b exp 1", ready1);
    end
    d1 = w;
    valid1 = 1'b1;
    step();
    valid1 = 1'b0;
    for (int k = 1; k <= FL1; k++) begin
      if (k > 1) step();
      checks++;
      if ({sdo1, busy1, ready1} !== {exp_sdo(w, 1, k), 1'b1, (k == FL1)}) begin
        errors++;
        $display("FAIL div1 cyc %0d got %b exp %b", k, {sdo1, busy1, ready1},
                 {exp_sdo(w, 1, k), 1'b1, (k == FL1)});
      end
    end
    step();
    checks++;
    if ({sdo1, busy1, ready1} !== 3'b101) begin
      errors++;
      $display("FAIL div1 post_idle got %b exp 101", {sdo1, busy1, ready1});
    end
  endtask

  task automatic test_random();
    logic [W-1:0] w;
    int           gap;
    for (int n = 0; n < 8; n++) begin
      w = W'($urandom);
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        valid = 1'b0;
        step();
        checks++;
        if ({sdo, busy, ready} !== 3'b101) begin
          errors++;
          $display("FAIL rand_gap n %0d got %b exp 101", n, {sdo, busy, ready});
        end
      end
      test_frame(w, 1'b1, "random");
    end
  endtask

  initial begin
    r = 1'b0;
    d = '0;
    valid = 1'b0;
    d1 = '0;
    valid1 = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_d_change();
    test_reset_mid();
    test_div1();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
